// File: rtl/picobello_offload_responder.sv
// picobello_offload_responder: fixed-latency integer reduction offload unit.
// A request is evaluated combinationally at acceptance and captured into stage 0;
// the remaining Latency-1 stages only delay the result. The whole pipeline
// shifts in lockstep whenever the output is not stalled.
// Optional feature macro: PICOBELLO_OFFLOAD_RSP_MUL_EN (enables the A_Mul opcode).
module picobello_offload_responder #(
  parameter int unsigned DataWidth = 64,
  parameter int unsigned Latency   = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [1:0][DataWidth-1:0] req_operands_i,
  input  logic [3:0]                req_operation_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  output logic [DataWidth-1:0]      rsp_result_o,
  output logic                      rsp_error_o,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [2:0]                inflight_o,
  output logic [31:0]               done_cnt_o
);

  typedef enum logic [3:0] {
    R_Select = 4'd0,
    F_Add    = 4'd4,
    A_Add    = 4'd8,
    A_Mul    = 4'd9,
    A_Min_S  = 4'd10,
    A_Max_S  = 4'd11,
    A_Min_U  = 4'd14,
    A_Max_U  = 4'd15
  } reduction_op_t;

  reduction_op_t               op;
  logic [DataWidth-1:0]        op0;
  logic [DataWidth-1:0]        op1;
  logic [DataWidth-1:0]        calc_res;
  logic                        calc_err;
  logic                        advance;

  logic [Latency-1:0]                vld_q, vld_d;
  logic [Latency-1:0]                err_q, err_d;
  logic [Latency-1:0][DataWidth-1:0] res_q, res_d;
  logic [31:0]                       done_cnt_q, done_cnt_d;

  assign op  = reduction_op_t'(req_operation_i);
  assign op0 = req_operands_i[0];
  assign op1 = req_operands_i[1];

  // Result and unsupported-opcode flag for the request currently offered.
  always_comb begin
    calc_res = '0;
    calc_err = 1'b0;
    case (op)
      R_Select: calc_res = op0;
      A_Add:    calc_res = op1 + op0;
`ifdef PICOBELLO_OFFLOAD_RSP_MUL_EN
      A_Mul:    calc_res = op1 * op0;
`endif
      A_Min_S:  calc_res = ($signed(op1) < $signed(op0)) ? op1 : op0;
      A_Max_S:  calc_res = ($signed(op1) > $signed(op0)) ? op1 : op0;
      A_Min_U:  calc_res = (op1 < op0) ? op1 : op0;
      A_Max_U:  calc_res = (op1 > op0) ? op1 : op0;
      default:  calc_err = 1'b1;
    endcase
  end

  // Output side: the pipeline may move unless a valid response is being held.
  // req_ready_o is therefore combinational from rsp_ready_i.
  assign rsp_valid_o  = vld_q[Latency-1];
  assign rsp_result_o = res_q[Latency-1];
  assign rsp_error_o  = err_q[Latency-1];
  assign advance      = !(rsp_valid_o && !rsp_ready_i);
  assign req_ready_o  = advance;
  assign done_cnt_o   = done_cnt_q;

  // Next-state of the stage registers: shift everything (bubbles included) on advance.
  always_comb begin
    vld_d = vld_q;
    err_d = err_q;
    res_d = res_q;
    if (advance) begin
      vld_d[0] = req_valid_i;
      err_d[0] = req_valid_i & calc_err;
      res_d[0] = req_valid_i ? calc_res : '0;
      for (int unsigned i = 1; i < Latency; i++) begin
        vld_d[i] = vld_q[i-1];
        err_d[i] = err_q[i-1];
        res_d[i] = res_q[i-1];
      end
    end
  end

  // Completed-response counter, free-running with natural 32-bit wrap.
  always_comb begin
    done_cnt_d = done_cnt_q;
    if (rsp_valid_o && rsp_ready_i) begin
      done_cnt_d = done_cnt_q + 32'd1;
    end
  end

  // Occupancy is the number of valid stages.
  always_comb begin
    inflight_o = '0;
    for (int unsigned i = 0; i < Latency; i++) begin
      inflight_o = inflight_o + 3'(vld_q[i]);
    end
  end

  // State registers; reset drops any in-flight work.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q      <= '0;
      err_q      <= '0;
      res_q      <= '0;
      done_cnt_q <= '0;
    end else begin
      vld_q      <= vld_d;
      err_q      <= err_d;
      res_q      <= res_d;
      done_cnt_q <= done_cnt_d;
    end
  end

endmodule

// File: tb/tb_picobello_offload_responder.sv
// Directed bench for picobello_offload_responder (DataWidth=64, Latency=2).
module tb_picobello_offload_responder;

  logic             clk;
  logic             rst_n;
  logic [1:0][63:0] operands;
  logic [3:0]       operation;
  logic             req_valid;
  logic             req_ready;
  logic [63:0]      rsp_result;
  logic             rsp_error;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [2:0]       inflight;
  logic [31:0]      done_cnt;

  int pass_cnt = 0;
  int total_cnt = 0;

  picobello_offload_responder #(
    .DataWidth(64),
    .Latency  (2)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .req_operands_i (operands),
    .req_operation_i(operation),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .rsp_result_o   (rsp_result),
    .rsp_error_o    (rsp_error),
    .rsp_valid_o    (rsp_valid),
    .rsp_ready_i    (rsp_ready),
    .inflight_o     (inflight),
    .done_cnt_o     (done_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else pass_cnt++;
  endtask

  typedef struct {
    string      name;
    logic [3:0] op;
    logic [63:0] a1;
    logic [63:0] a0;
    logic [63:0] res;
    logic        err;
  } vec_t;

  vec_t tbl[10];

  // Single request with no backpressure: accept, check latency, result and count.
  task automatic run_vec(input vec_t v, input int idx);
    @(negedge clk);
    operation   = v.op;
    operands[1] = v.a1;
    operands[0] = v.a0;
    req_valid   = 1'b1;
    rsp_ready   = 1'b1;
    #1 chk({v.name, "_req_ready"}, 64'(req_ready), 64'd1);
    @(negedge clk);
    req_valid = 1'b0;
    #1 chk({v.name, "_valid_early"}, 64'(rsp_valid), 64'd0);
    @(negedge clk);
    #1;
    chk({v.name, "_valid"}, 64'(rsp_valid), 64'd1);
    chk({v.name, "_result"}, rsp_result, v.res);
    chk({v.name, "_error"}, 64'(rsp_error), 64'(v.err));
    @(negedge clk);
    #1 chk({v.name, "_done_cnt"}, 64'(done_cnt), 64'(idx + 1));
  endtask

  initial begin
    logic [63:0] ones;
    int sent, got, stale, done_before;
    bit in_hs, found;

    ones = '1;
    tbl[0] = '{"add_5_7",   4'd8,  64'd5, 64'd7,  64'd12, 1'b0};
    tbl[1] = '{"min_s",     4'd10, ones,  64'd3,  ones,   1'b0};
    tbl[2] = '{"min_u",     4'd14, ones,  64'd3,  64'd3,  1'b0};
    tbl[3] = '{"max_s",     4'd11, ones,  64'd3,  64'd3,  1'b0};
    tbl[4] = '{"max_u",     4'd15, ones,  64'd3,  ones,   1'b0};
    tbl[5] = '{"select",    4'd0,  64'd9, 64'h55, 64'h55, 1'b0};
    tbl[6] = '{"f_add",     4'd4,  64'd1, 64'd2,  64'd0,  1'b1};
`ifdef PICOBELLO_OFFLOAD_RSP_MUL_EN
    tbl[7] = '{"mul_6_7",   4'd9,  64'd6, 64'd7,  64'd42, 1'b0};
`else
    tbl[7] = '{"mul_6_7",   4'd9,  64'd6, 64'd7,  64'd0,  1'b1};
`endif
    tbl[8] = '{"add_wrap",  4'd8,  ones,  64'd1,  64'd0,  1'b0};
    tbl[9] = '{"op12",      4'd12, 64'd4, 64'd4,  64'd0,  1'b1};

    rst_n     = 1'b0;
    operands  = '0;
    operation = '0;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_inflight",  64'(inflight),  64'd0);
    chk("rst_done_cnt",  64'(done_cnt),  64'd0);
    chk("rst_result",    rsp_result,     64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(tbl[i], i);

    // Backpressure: two requests fill the pipe, third waits.
    done_before = int'(done_cnt);
    @(negedge clk);
    rsp_ready = 1'b0;
    operation = 4'd8;
    req_valid = 1'b1;
    operands[1] = 64'd100; operands[0] = 64'd1;
    @(negedge clk);
    operands[1] = 64'd200; operands[0] = 64'd2;
    @(negedge clk);
    operands[1] = 64'd300; operands[0] = 64'd3;
    #1;
    chk("stall_inflight",  64'(inflight),  64'd2);
    chk("stall_req_ready", 64'(req_ready), 64'd0);
    chk("stall_valid",     64'(rsp_valid), 64'd1);
    chk("stall_head",      rsp_result,     64'd101);
    @(negedge clk);
    #1;
    chk("stall_head_hold", rsp_result,     64'd101);
    chk("stall_inflight2", 64'(inflight),  64'd2);

    rsp_ready = 1'b1;
    sent = 2;
    got  = 0;
    for (int cyc = 0; cyc < 20 && got < 4; cyc++) begin
      if (sent < 4) begin
        req_valid   = 1'b1;
        operands[1] = 64'(100 * (sent + 1));
        operands[0] = 64'(sent + 1);
      end else begin
        req_valid = 1'b0;
      end
      #1;
      if (rsp_valid && rsp_ready) begin
        chk("drain_order", rsp_result, 64'(101 * (got + 1)));
        got++;
      end
      in_hs = req_valid && req_ready;
      @(negedge clk);
      if (in_hs) sent++;
      if (cyc == 0) chk("drain_refill_inflight", 64'(inflight), 64'd2);
    end
    req_valid = 1'b0;
    chk("drain_count", 64'(got),  64'd4);
    chk("drain_sent",  64'(sent), 64'd4);
    #1 chk("drain_done_cnt", 64'(done_cnt), 64'(done_before + 4));

    // Reset in the middle of a full, stalled pipeline.
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    operands[1] = 64'd10; operands[0] = 64'd20;
    @(negedge clk);
    operands[1] = 64'd30; operands[0] = 64'd40;
    @(negedge clk);
    req_valid = 1'b0;
    #1 chk("pre_rst_inflight", 64'(inflight), 64'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid",     64'(rsp_valid), 64'd0);
    chk("arst_result",    rsp_result,     64'd0);
    chk("arst_error",     64'(rsp_error), 64'd0);
    chk("arst_inflight",  64'(inflight),  64'd0);
    chk("arst_req_ready", 64'(req_ready), 64'd1);
    chk("arst_done_cnt",  64'(done_cnt),  64'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      #1 if (rsp_valid) stale++;
    end
    chk("no_stale_rsp", 64'(stale), 64'd0);

    // Counter wrap: preload near the top, then one handshake.
    @(negedge clk);
    operation = 4'd8;
    operands[1] = 64'd1; operands[0] = 64'd1;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    found = 1'b0;
    for (int cyc = 0; cyc < 10 && !found; cyc++) begin
      #1;
      if (rsp_valid) found = 1'b1;
      else @(negedge clk);
    end
    chk("wrap_rsp_seen", 64'(found), 64'd1);
    if (found) begin
      force dut.done_cnt_q = 32'hFFFF_FFFF;
      #1 release dut.done_cnt_q;
      #1;
      chk("wrap_preload", 64'(done_cnt), 64'hFFFF_FFFF);
      chk("wrap_result",  rsp_result,    64'd2);
      @(negedge clk);
      #1 chk("wrap_done_cnt", 64'(done_cnt), 64'd0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
